// File: rtl/trig_out_pkg.sv
// rtl/trig_out_pkg.sv - shared state encoding, counter width default and saturating increment
package trig_out_pkg;

    // FSM state encoding shared by the trigger-out path
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EMIT    = 2'd1;
    localparam logic [1:0] ST_HOLDOFF = 2'd2;

    // Default width of the emit / coalesce statistics counters
    localparam int TRIG_CNT_W = 16;

    // Increment that sticks at the all-ones value of a width-bit counter
    function automatic logic [63:0] sat_inc(input logic [63:0] val, input int width);
        logic [63:0] max_val;
        max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (val >= max_val) ? max_val : val + 64'd1;
    endfunction

endpackage

// File: rtl/event_holdoff_timer.sv
// rtl/event_holdoff_timer.sv - loadable down-counter timing the holdoff window
module event_holdoff_timer #(
    parameter int W = 4
) (
    input  logic         clk1,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] r_cnt;

    // Load on request, otherwise count down and rest at zero
    always_ff @(posedge clk1) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign done = (r_cnt == '0);

endmodule

// File: rtl/event_trigger_out.sv
// rtl/event_trigger_out.sv - latches event pulses and emits rate-limited trigger vectors (optional EVENT_TIMESTAMP_EN)
module event_trigger_out
    import trig_out_pkg::*;
#(
    parameter int N_EVENTS    = 16,
    parameter int HOLDOFF_CYC = 8,
    parameter int CNT_W       = TRIG_CNT_W
) (
    input  logic                clk1,
    input  logic                reset,
    input  logic [N_EVENTS-1:0] ev_in,
    input  logic [N_EVENTS-1:0] ev_mask,
    input  logic                clear_stats,
    output logic [N_EVENTS-1:0] ep_trigger,
    output logic [CNT_W-1:0]    trig_count,
    output logic [CNT_W-1:0]    coalesce_count,
    output logic                busy
`ifdef EVENT_TIMESTAMP_EN
    ,
    output logic [31:0]         ts_last,
    output logic                ts_valid
`endif
);

    // Timer only needs to hold HOLDOFF_CYC-1
    localparam int TW = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;
    localparam logic [TW-1:0] HOLD_LOAD = TW'((HOLDOFF_CYC > 0) ? HOLDOFF_CYC - 1 : 0);

    logic [1:0]          r_state;
    logic [N_EVENTS-1:0] r_pending;
    logic [N_EVENTS-1:0] r_ep_trigger;
    logic [CNT_W-1:0]    r_trig_count;
    logic [CNT_W-1:0]    r_coal_count;

    logic [N_EVENTS-1:0] w_capture;
    logic [N_EVENTS-1:0] w_pending_next;
    logic                w_in_emit;
    logic                w_coalesce;
    logic                w_timer_done;
    logic [CNT_W-1:0]    w_trig_inc;
    logic [CNT_W-1:0]    w_coal_inc;

    assign w_capture      = ev_in & ev_mask;
    assign w_pending_next = r_pending | w_capture;
    assign w_in_emit      = (r_state == ST_EMIT);
    // The emit cycle hands all pending bits out, so nothing can merge into them then
    assign w_coalesce     = !w_in_emit && ((w_capture & r_pending) != '0);
    assign w_trig_inc     = CNT_W'(sat_inc(64'(r_trig_count), CNT_W));
    assign w_coal_inc     = CNT_W'(sat_inc(64'(r_coal_count), CNT_W));

    event_holdoff_timer #(
        .W        (TW)
    ) u_holdoff (
        .clk1     (clk1),
        .reset    (reset),
        .load     (w_in_emit),
        .load_val (HOLD_LOAD),
        .done     (w_timer_done)
    );

    // State sequencing; IDLE looks at this cycle's captures so a lone event emits two cycles later
    always_ff @(posedge clk1) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pending_next != '0) begin
                        r_state <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    r_state <= (HOLDOFF_CYC > 0) ? ST_HOLDOFF : ST_IDLE;
                end
                ST_HOLDOFF: begin
                    if (w_timer_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Pending set: emit hands the snapshot out and keeps only this cycle's fresh captures
    always_ff @(posedge clk1) begin
        if (reset) begin
            r_pending <= '0;
        end else if (w_in_emit) begin
            r_pending <= w_capture;
        end else begin
            r_pending <= w_pending_next;
        end
    end

    // One-cycle trigger vector, zero outside the cycle after EMIT
    always_ff @(posedge clk1) begin
        if (reset) begin
            r_ep_trigger <= '0;
        end else begin
            r_ep_trigger <= w_in_emit ? r_pending : '0;
        end
    end

    // Saturating statistics; clear beats a coincident increment
    always_ff @(posedge clk1) begin
        if (reset || clear_stats) begin
            r_trig_count <= '0;
            r_coal_count <= '0;
        end else begin
            if (w_in_emit) begin
                r_trig_count <= w_trig_inc;
            end
            if (w_coalesce) begin
                r_coal_count <= w_coal_inc;
            end
        end
    end

`ifdef EVENT_TIMESTAMP_EN
    logic [31:0] r_ts;
    logic [31:0] r_ts_last;
    logic        r_ts_valid;

    // Free-running timestamp, sampled in the emit cycle so it lines up with ep_trigger
    always_ff @(posedge clk1) begin
        if (reset) begin
            r_ts       <= '0;
            r_ts_last  <= '0;
            r_ts_valid <= 1'b0;
        end else begin
            r_ts       <= r_ts + 32'd1;
            r_ts_valid <= w_in_emit;
            if (w_in_emit) begin
                r_ts_last <= r_ts;
            end
        end
    end

    assign ts_last  = r_ts_last;
    assign ts_valid = r_ts_valid;
`endif

    assign ep_trigger     = r_ep_trigger;
    assign trig_count     = r_trig_count;
    assign coalesce_count = r_coal_count;
    assign busy           = (r_state != ST_IDLE);

endmodule

// File: tb/tb_event_trigger_out.sv
// tb/tb_event_trigger_out.sv - randomized scoreboard bench for event_trigger_out
module tb_event_trigger_out;

    localparam logic [15:0] M_ALL = 16'hFFFF;

    bit          clk1 = 1'b0;
    logic        reset;
    logic [15:0] ev_in;
    logic [15:0] ev_mask;
    logic        clear_stats;

    logic [15:0] ep_a, ep_b;
    logic [15:0] trig_a, coal_a;
    logic [3:0]  trig_b, coal_b;
    logic        busy_a, busy_b;
`ifdef EVENT_TIMESTAMP_EN
    logic [31:0] ts_a, ts_b;
    logic        tsv_a, tsv_b;
`endif

    always #5 clk1 = ~clk1;

    // Instance A: default build; instance B: no holdoff and narrow counters
    event_trigger_out #(.N_EVENTS(16), .HOLDOFF_CYC(8), .CNT_W(16)) u_dut_a (
        .clk1(clk1), .reset(reset), .ev_in(ev_in), .ev_mask(ev_mask),
        .clear_stats(clear_stats), .ep_trigger(ep_a), .trig_count(trig_a),
        .coalesce_count(coal_a), .busy(busy_a)
`ifdef EVENT_TIMESTAMP_EN
        , .ts_last(ts_a), .ts_valid(tsv_a)
`endif
    );

    event_trigger_out #(.N_EVENTS(16), .HOLDOFF_CYC(0), .CNT_W(4)) u_dut_b (
        .clk1(clk1), .reset(reset), .ev_in(ev_in), .ev_mask(ev_mask),
        .clear_stats(clear_stats), .ep_trigger(ep_b), .trig_count(trig_b),
        .coalesce_count(coal_b), .busy(busy_b)
`ifdef EVENT_TIMESTAMP_EN
        , .ts_last(ts_b), .ts_valid(tsv_b)
`endif
    );

    typedef struct {
        logic [15:0] vec;
        logic [31:0] trig;
        logic [31:0] coal;
        logic        busy;
        logic [31:0] ts;
    } rec_t;

    rec_t q_a[$];
    rec_t q_b[$];

    int n_assert = 0;
    int n_fail   = 0;
    int mon_cyc  = 0;

    // Reference model state: cycle-indexed schedule rather than an FSM
    int          m_cyc = 0;
    logic [15:0] m_pend[2];
    int          m_emit_at[2];
    int          m_busy_end[2];
    int          m_trig[2];
    int          m_coal[2];
    logic [31:0] m_ts_last[2];
    logic [31:0] m_ts = 0;

    function automatic int hold_of(input int i);
        return (i == 0) ? 8 : 0;
    endfunction

    function automatic int max_of(input int i);
        return (i == 0) ? 65535 : 15;
    endfunction

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d cyc%0d: got %0h expected %0h", name, inst, mon_cyc, act, exp);
        end
    endtask

    // Predict what each instance shows after the coming clock edge
    task automatic model_step(input logic [15:0] ev, input logic [15:0] mask, input logic clr, input logic rst);
        for (int i = 0; i < 2; i++) begin
            rec_t        r;
            logic [15:0] cap;
            logic        tinc;
            logic        cinc;
            r.vec = '0;
            tinc  = 1'b0;
            cinc  = 1'b0;
            if (rst) begin
                m_pend[i]     = '0;
                m_emit_at[i]  = -1;
                m_busy_end[i] = -1;
                m_trig[i]     = 0;
                m_coal[i]     = 0;
                m_ts_last[i]  = '0;
                r.busy        = 1'b0;
            end else begin
                cap = ev & mask;
                if (m_emit_at[i] == m_cyc) begin
                    r.vec         = m_pend[i];
                    m_pend[i]     = cap;
                    tinc          = 1'b1;
                    m_busy_end[i] = m_cyc + hold_of(i);
                    m_emit_at[i]  = -1;
                    m_ts_last[i]  = m_ts;
                end else begin
                    cinc      = ((cap & m_pend[i]) != '0);
                    m_pend[i] = m_pend[i] | cap;
                    if (m_cyc > m_busy_end[i] && m_pend[i] != '0) m_emit_at[i] = m_cyc + 1;
                end
                if (clr) begin
                    m_trig[i] = 0;
                    m_coal[i] = 0;
                end else begin
                    if (tinc && m_trig[i] < max_of(i)) m_trig[i]++;
                    if (cinc && m_coal[i] < max_of(i)) m_coal[i]++;
                end
                r.busy = (m_emit_at[i] == m_cyc + 1) || (m_cyc + 1 <= m_busy_end[i]);
            end
            r.trig = m_trig[i];
            r.coal = m_coal[i];
            r.ts   = m_ts_last[i];
            if (i == 0) q_a.push_back(r);
            else        q_b.push_back(r);
        end
        m_ts  = rst ? 32'd0 : m_ts + 32'd1;
        m_cyc = m_cyc + 1;
    endtask

    task automatic step(input logic [15:0] ev, input logic [15:0] mask, input logic clr, input logic rst);
        ev_in       = ev;
        ev_mask     = mask;
        clear_stats = clr;
        reset       = rst;
        model_step(ev, mask, clr, rst);
        @(posedge clk1);
        #1;
    endtask

    task automatic idle(input int n, input logic [15:0] mask);
        repeat (n) step(16'h0, mask, 1'b0, 1'b0);
    endtask

    // Monitor: pop one prediction per cycle and compare, away from the active edge
    always @(negedge clk1) begin
        rec_t r;
        mon_cyc++;
        if (q_a.size() > 0) begin
            r = q_a.pop_front();
            chk("ep_trigger", 0, {16'h0, ep_a}, {16'h0, r.vec});
            chk("trig_count", 0, {16'h0, trig_a}, r.trig);
            chk("coalesce_count", 0, {16'h0, coal_a}, r.coal);
            chk("busy", 0, {31'h0, busy_a}, {31'h0, r.busy});
`ifdef EVENT_TIMESTAMP_EN
            chk("ts_valid", 0, {31'h0, tsv_a}, {31'h0, (r.vec != 16'h0)});
            chk("ts_last", 0, ts_a, r.ts);
`endif
        end
        if (q_b.size() > 0) begin
            r = q_b.pop_front();
            chk("ep_trigger", 1, {16'h0, ep_b}, {16'h0, r.vec});
            chk("trig_count", 1, {28'h0, trig_b}, r.trig);
            chk("coalesce_count", 1, {28'h0, coal_b}, r.coal);
            chk("busy", 1, {31'h0, busy_b}, {31'h0, r.busy});
`ifdef EVENT_TIMESTAMP_EN
            chk("ts_valid", 1, {31'h0, tsv_b}, {31'h0, (r.vec != 16'h0)});
            chk("ts_last", 1, ts_b, r.ts);
`endif
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [15:0] rmask;
        logic [15:0] rev;

        step(16'h0, M_ALL, 1'b0, 1'b1);
        step(16'h0, M_ALL, 1'b0, 1'b1);
        idle(5, M_ALL);

        // Lone event
        step(16'h0008, M_ALL, 1'b0, 1'b0);
        idle(15, M_ALL);

        // Events merging during holdoff, then a coalesce
        step(16'h0001, M_ALL, 1'b0, 1'b0);
        idle(3, M_ALL);
        step(16'h0020, M_ALL, 1'b0, 1'b0);
        step(16'h0001, M_ALL, 1'b0, 1'b0);
        step(16'h0020, M_ALL, 1'b0, 1'b0);
        idle(20, M_ALL);

        // Masked events never become pending
        step(16'hFF00, 16'h00FF, 1'b0, 1'b0);
        idle(5, 16'h00FF);
        idle(10, M_ALL);

        // Reset during holdoff with a bit pending
        step(16'h0001, M_ALL, 1'b0, 1'b0);
        idle(3, M_ALL);
        step(16'h0010, M_ALL, 1'b0, 1'b0);
        step(16'h0000, M_ALL, 1'b0, 1'b1);
        idle(15, M_ALL);

        // Drive instance B past its 4-bit counter range
        repeat (40) step(16'h0100, M_ALL, 1'b0, 1'b0);
        chk("trig_count_saturated", 1, {28'h0, trig_b}, 32'hF);
        step(16'h0100, M_ALL, 1'b1, 1'b0);
        step(16'h0100, M_ALL, 1'b1, 1'b0);
        idle(12, M_ALL);

        // Random traffic
        rmask = M_ALL;
        repeat (3000) begin
            if ($urandom_range(0, 99) == 0) rmask = 16'($urandom);
            rev = ($urandom_range(0, 3) == 0) ? 16'($urandom & $urandom & $urandom) : 16'h0;
            step(rev, rmask, ($urandom_range(0, 59) == 0), ($urandom_range(0, 399) == 0));
        end
        idle(12, M_ALL);

        @(negedge clk1);
        #1;
        chk("scoreboard_drained", 0, q_a.size(), 0);
        chk("scoreboard_drained", 1, q_b.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
